// File: rtl/regfile_wb_arb.sv
// Register-file write-back arbiter: round-robin grant of one requester per
// cycle onto a single registered write port, plus a pending-write scoreboard.
module regfile_wb_arb #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_stall,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rw,
  output logic [DW-1:0]        rf_wdata,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        chk_ra,
  input  logic [AW-1:0]        chk_rb,
  output logic                 hazard_a,
  output logic                 hazard_b,
  output logic [(2**AW)-1:0]   busy
);

  localparam int NREG = 2**AW;

  // Handshake: requester i transfers on a cycle where req_valid[i] & req_ready[i];
  // req_ready is combinational, depends on req_valid, and never waits on itself.

  logic [1:0]      ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rw_q, rf_rw_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic            found;
  logic            go;
  logic [1:0]      grant_idx;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  // Two passes implement the circular search starting at ptr.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(ptr_q))) begin
        found     = 1'b1;
        grant_idx = i[1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (i < int'(ptr_q))) begin
        found     = 1'b1;
        grant_idx = i[1:0];
      end
    end
    go = found && !wb_stall && rst_n;
  end

  always_comb begin
    req_ready = '0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == i[1:0]) begin
        req_ready[i] = go;
        sel_rd       = req_rd[i*AW +: AW];
        sel_data     = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (go) begin
      if (int'(grant_idx) == NREQ - 1) ptr_d = '0;
      else                             ptr_d = grant_idx + 2'd1;
    end
  end

  // A grant to r0 completes the handshake but leaves the write port idle.
  always_comb begin
    rf_we_d    = go && (sel_rd != '0);
    rf_rw_d    = rf_rw_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_rw_d    = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  // Set is applied after clear so a same-cycle issue to the register wins.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      set_vec[r] = issue_valid && (issue_rd == r[AW-1:0]);
      clr_vec[r] = go && (sel_rd == r[AW-1:0]);
    end
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_rw_q    <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rw_q    <= rf_rw_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rw    = rf_rw_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = pending_q;
  assign hazard_a = pending_q[chk_ra];
  assign hazard_b = pending_q[chk_rb];

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: hand-computed grants, write-port values
// and scoreboard bits checked with immediate assertions.
module tb_regfile_wb_arb;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 4;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_rd;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                wb_stall;
  logic                rf_we;
  logic [AW-1:0]       rf_rw;
  logic [DW-1:0]       rf_wdata;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [AW-1:0]       chk_ra;
  logic [AW-1:0]       chk_rb;
  logic                hazard_a;
  logic                hazard_b;
  logic [(2**AW)-1:0]  busy;

  int checks;
  int errors;

  regfile_wb_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_ra(chk_ra), .chk_rb(chk_rb),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = data;
  endtask

  logic [NREQ-1:0] exp_seq [6];
  logic [AW-1:0]   exp_rd  [3];
  logic [DW-1:0]   exp_dat [3];

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; req_valid = '0; req_rd = '0; req_data = '0; wb_stall = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; chk_ra = '0; chk_rb = '0;

    // Reset state, with requests and an issue presented during reset
    req_valid = 3'b111; issue_valid = 1'b1; issue_rd = 4'd6; chk_ra = 4'd6;
    tick(); tick();
    check("rst_ready", req_ready, 3'b000);
    check("rst_we", rf_we, 1'b0);
    check("rst_rw", rf_rw, 4'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_busy", busy, 16'h0000);
    check("rst_haz_a", hazard_a, 1'b0);

    // Release, ALU only rd=5
    rst_n = 1'b1; req_valid = 3'b001; issue_valid = 1'b0; issue_rd = '0; chk_ra = '0;
    set_req(0, 4'd5, 32'hDEADBEEF);
    settle();
    check("alu_ready", req_ready, 3'b001);
    tick();
    check("alu_we", rf_we, 1'b1);
    check("alu_rw", rf_rw, 4'd5);
    check("alu_wdata", rf_wdata, 32'hDEADBEEF);

    // LSU grant to r0: handshake only, write port holds (ptr 1 -> 2 -> 0)
    req_valid = 3'b100; set_req(2, 4'd0, 32'h12345678);
    issue_valid = 1'b1; issue_rd = 4'd0;
    settle();
    check("lsu0_ready", req_ready, 3'b100);
    tick();
    issue_valid = 1'b0;
    check("lsu0_we", rf_we, 1'b0);
    check("lsu0_rw_hold", rf_rw, 4'd5);
    check("lsu0_wdata_hold", rf_wdata, 32'hDEADBEEF);
    check("issue0_busy", busy, 16'h0000);

    // Round robin, all valid for 6 cycles from ptr=0
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;
    exp_rd[0] = 4'd1; exp_rd[1] = 4'd2; exp_rd[2] = 4'd3;
    exp_dat[0] = 32'hA1A1A1A1; exp_dat[1] = 32'hB2B2B2B2; exp_dat[2] = 32'hC3C3C3C3;
    for (int i = 0; i < NREQ; i++) set_req(i, exp_rd[i], exp_dat[i]);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      settle();
      check($sformatf("rr_ready%0d", c), req_ready, exp_seq[c]);
      tick();
      check($sformatf("rr_we%0d", c), rf_we, 1'b1);
      check($sformatf("rr_rw%0d", c), rf_rw, exp_rd[c % 3]);
      check($sformatf("rr_wdata%0d", c), rf_wdata, exp_dat[c % 3]);
    end

    // One more grant to ALU so ptr=1, then stall 3 cycles
    settle();
    check("pre_stall_ready", req_ready, 3'b001);
    tick();
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("stall_ready%0d", c), req_ready, 3'b000);
      tick();
      check($sformatf("stall_we%0d", c), rf_we, 1'b0);
    end
    wb_stall = 1'b0;
    settle();
    check("post_stall_ready", req_ready, 3'b010);
    tick();
    check("post_stall_rw", rf_rw, 4'd2);
    check("post_stall_we", rf_we, 1'b1);
    req_valid = 3'b000;

    // Scoreboard: issue r7, MAC writes r7 four cycles later (ptr=2 now)
    issue_valid = 1'b1; issue_rd = 4'd7; chk_ra = 4'd7; chk_rb = 4'd0;
    tick();
    issue_valid = 1'b0; issue_rd = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        req_valid = 3'b010; set_req(1, 4'd7, 32'h00000077);
      end
      settle();
      check($sformatf("pend7_busy%0d", c), busy, 16'h0080);
      check($sformatf("pend7_haz_a%0d", c), hazard_a, 1'b1);
      check($sformatf("pend7_haz_b%0d", c), hazard_b, 1'b0);
      if (c == 3) check("mac7_ready", req_ready, 3'b010);
      tick();
    end
    req_valid = 3'b000;
    check("clr7_busy", busy, 16'h0000);
    check("clr7_haz_a", hazard_a, 1'b0);
    check("mac7_we", rf_we, 1'b1);
    check("mac7_rw", rf_rw, 4'd7);
    check("mac7_wdata", rf_wdata, 32'h00000077);

    // Set wins over same-cycle clear on r3 (ptr=2, LSU granted)
    issue_valid = 1'b1; issue_rd = 4'd3;
    tick();
    check("set3_busy", busy, 16'h0008);
    req_valid = 3'b100; set_req(2, 4'd3, 32'h33333333); chk_rb = 4'd3;
    settle();
    check("lsu3_ready", req_ready, 3'b100);
    tick();
    issue_valid = 1'b0; issue_rd = '0; req_valid = 3'b000;
    check("setwin3_busy", busy, 16'h0008);
    check("setwin3_haz_b", hazard_b, 1'b1);
    check("lsu3_rw", rf_rw, 4'd3);

    // Grant ALU (ptr 0 -> 1), then async reset in the following cycle
    req_valid = 3'b001; set_req(0, 4'd9, 32'h99999999);
    issue_valid = 1'b1; issue_rd = 4'd4;
    tick();
    req_valid = 3'b000; issue_valid = 1'b0; issue_rd = '0;
    check("pre_rst_we", rf_we, 1'b1);
    check("pre_rst_busy", busy, 16'h0018);
    rst_n = 1'b0; req_valid = 3'b101;
    settle();
    check("async_rst_we", rf_we, 1'b0);
    check("async_rst_busy", busy, 16'h0000);
    check("async_rst_ready", req_ready, 3'b000);
    check("async_rst_haz_b", hazard_b, 1'b0);
    tick();
    rst_n = 1'b1; req_valid = 3'b000;
    tick();
    check("post_rst_no_we", rf_we, 1'b0);
    req_valid = 3'b101; set_req(0, 4'd10, 32'hAAAA0000);
    settle();
    check("post_rst_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check("post_rst_rw", rf_rw, 4'd10);
    check("post_rst_wdata", rf_wdata, 32'hAAAA0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter: NREQ, 3, number of write-back requesters (0=ALU, 1=MAC, 2=LSU).
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: AW, 4, register address width (16 registers).
REQ-004 Clocking: one clock; reset asynchronous, active-low.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NREQ  write-back request per requester.
REQ-008 req_rd  input  NREQ*AW  destination register; requester i at bits [i*AW +: AW].
REQ-009 req_data  input  NREQ*DW  write data; requester i at bits [i*DW +: DW].
REQ-010 req_ready  output  NREQ  grant; transfer occurs when req_valid[i] & req_ready[i].
REQ-011 wb_stall  input  1  blocks all grants while high.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_rw  output  AW  register-file write address.
REQ-014 rf_wdata  output  DW  register-file write data.
REQ-015 issue_valid  input  1  instruction issued that will write issue_rd.
REQ-016 issue_rd  input  AW  destination register of issued instruction.
REQ-017 chk_ra, chk_rb  input  AW each  source registers of the instruction in decode.
REQ-018 hazard_a, hazard_b  output  1 each  source register has a pending write.
REQ-019 busy  output  2**AW  pending-write scoreboard vector.

Function
REQ-020 The block shall grant at most one requester per cycle, because the register file has one write port.
REQ-021 req_ready shall be combinational: req_ready[i]=1 only for the selected requester, and only when req_valid[i]=1 and wb_stall=0.
REQ-022 Selection shall be round-robin: search starts at pointer ptr (2 bits, range 0..NREQ-1) and takes the first valid requester in order ptr, ptr+1, ... modulo NREQ.
REQ-023 After a grant to requester i, ptr shall become (i+1) mod NREQ; without a grant, ptr shall be unchanged.
REQ-024 A granted transfer shall appear on rf_we/rf_rw/rf_wdata in the next cycle (latency 1, registered outputs).
REQ-025 rf_we shall be 1 only in the cycle after a grant whose rd is nonzero; a grant with rd=0 shall complete the handshake with rf_we=0.
REQ-026 While rf_we=0, rf_rw and rf_wdata shall hold their previous values.
REQ-027 Scoreboard pending[r] shall be set at the clock edge where issue_valid=1 and issue_rd=r, for r nonzero.
REQ-028 pending[r] shall be cleared at the edge where a grant to rd=r occurs.
REQ-029 If set and clear for the same register occur in the same cycle, set shall win.
REQ-030 pending[0] shall be constantly 0; busy shall equal pending.
REQ-031 hazard_a = pending[chk_ra] and hazard_b = pending[chk_rb], both combinational.
REQ-032 Register 0 shall never report a hazard.
REQ-033 Two requesters with the same rd in consecutive grants shall be written in grant order with no merging.

Reset
REQ-034 While rst_n=0: ptr=0, pending=0, rf_we=0, rf_rw=0, rf_wdata=0, req_ready=0. busy, hazard_a and hazard_b shall all read 0.
REQ-035 Reset asserted mid-transfer shall discard the registered write; after reset release, no rf_we pulse shall occur until a new grant.
REQ-036 The first grant after reset release shall be evaluated from ptr=0.

Verification
REQ-037 Reset release, then ALU only: rd=5, data=0xDEADBEEF -> req_ready=001 that cycle; next cycle rf_we=1, rf_rw=5, rf_wdata=0xDEADBEEF.
REQ-038 All three requesters held valid for 6 cycles, ptr=0 -> grant sequence 0,1,2,0,1,2; one rf_we pulse per cycle.
REQ-039 wb_stall=1 for 3 cycles with all valid -> req_ready=000 and rf_we=0 during the stall; after release, grants resume from the unchanged ptr.
REQ-040 issue rd=7, then MAC write-back rd=7 four cycles later -> busy[7]=1 and hazard_a=1 (chk_ra=7) for four cycles, then 0 after the grant edge.
REQ-041 LSU grant to rd=0 -> req_ready[2]=1, next cycle rf_we=0; issue rd=0 -> busy stays 0.
REQ-042 issue rd=3 in the same cycle as a grant to rd=3 -> busy[3]=1 afterwards.
REQ-043 rst_n pulsed low in the cycle after a grant -> rf_we=0, busy=0 immediately (asynchronous); the next grant goes to the lowest-index valid requester.
